// File: rtl/ussrt_responder.sv
// ussrt_responder: oversampling serial-link responder that deserialises a command word and serialises a response word
module ussrt_responder #(
  parameter int CMD_N          = 8,
  parameter int RESP_N         = 8,
  parameter int SAMPLE_EDGE    = 1,
  parameter int CMD_MSB_FIRST  = 1,
  parameter int RESP_MSB_FIRST = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csb,
  input  logic              sclk,
  input  logic              sdi,
  output logic              sdo,
  output logic [CMD_N-1:0]  cmd_data,
  output logic              cmd_valid,
  input  logic [RESP_N-1:0] resp_data,
  output logic              resp_done,
  output logic              frame_err,
  output logic              busy
);
  localparam int MAXN = CMD_N > RESP_N ? CMD_N : RESP_N;
  localparam int CW = $clog2(MAXN) + 1;
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_N - 1);
  localparam logic [CW-1:0] RESP_LAST = CW'(RESP_N - 1);
  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_s, csb_s, sdi_s;
  logic sclk_h, sclk_q, csb_q, sdi_q, rise, fall, smp, lau;
  logic [CW-1:0] cnt;
  logic [CMD_N-1:0] cmd_sr, cmd_nxt;
  logic [RESP_N-1:0] resp_sr;
  assign sclk_q = sclk_s[SYNC_STAGES-1];
  assign csb_q = csb_s[SYNC_STAGES-1];
  assign sdi_q = sdi_s[SYNC_STAGES-1];
  assign rise = sclk_q & ~sclk_h;
  assign fall = ~sclk_q & sclk_h;
  assign smp = ~csb_q & ((SAMPLE_EDGE != 0) ? rise : fall);
  assign lau = ~csb_q & ((SAMPLE_EDGE != 0) ? fall : rise);
  assign cmd_nxt = (CMD_MSB_FIRST != 0) ? {cmd_sr[CMD_N-2:0], sdi_q} : {sdi_q, cmd_sr[CMD_N-1:1]};
  assign busy = (state == RESP) || (state == CMD && cnt != '0);
  // equal-depth synchronisers keep sdi aligned with the sclk edge it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= '0;
      csb_s <= '0;
      sdi_s <= '0;
      sclk_h <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      csb_s <= {csb_s[SYNC_STAGES-2:0], csb};
      sdi_s <= {sdi_s[SYNC_STAGES-2:0], sdi};
      sclk_h <= sclk_q;
    end
  end
  // frame FSM: csb high overrides everything; response loads in the cmd_valid cycle and
  // only advances on launch edges that follow a response sample, so bit 0 survives the first launch
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cmd_sr <= '0;
      resp_sr <= '0;
      sdo <= 1'b0;
      cmd_data <= '0;
      cmd_valid <= 1'b0;
      resp_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      resp_done <= 1'b0;
      frame_err <= 1'b0;
      if (csb_q) begin
        state <= IDLE;
        cnt <= '0;
        sdo <= 1'b0;
        frame_err <= (cnt != '0) || (state == RESP);
      end else begin
        case (state)
          IDLE: begin
            state <= CMD;
            cnt <= '0;
          end
          CMD: if (smp) begin
            cmd_sr <= cmd_nxt;
            if (cnt == CMD_LAST) begin
              cmd_data <= cmd_nxt;
              cmd_valid <= 1'b1;
              state <= RESP;
              cnt <= '0;
            end else cnt <= cnt + 1'b1;
          end
          RESP: begin
            if (cmd_valid) begin
              resp_sr <= resp_data;
              sdo <= (RESP_MSB_FIRST != 0) ? resp_data[RESP_N-1] : resp_data[0];
            end else if (lau && cnt != '0) begin
              resp_sr <= (RESP_MSB_FIRST != 0) ? resp_sr << 1 : resp_sr >> 1;
              sdo <= (RESP_MSB_FIRST != 0) ? resp_sr[RESP_N-2] : resp_sr[1];
            end
            if (smp) begin
              if (cnt == RESP_LAST) begin
                resp_done <= 1'b1;
                sdo <= 1'b0;
                state <= CMD;
                cnt <= '0;
              end else cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ussrt_responder.sv
// tb_ussrt_responder: serial-master model driving two responder configurations with scoreboard checks
module tb_ussrt_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  logic csb [2];
  logic sclk [2];
  logic sdi [2];
  logic [7:0] resp_data [2];
  wire sdo [2];
  wire cmd_valid [2];
  wire resp_done [2];
  wire frame_err [2];
  wire busy [2];
  wire [7:0] cmd_data [2];
  int cmp = 0;
  int bad = 0;
  int cyc = 0;
  int cv_pend [2];
  int rd_pend [2];
  int fe_pend [2];
  int t_cmd [2];
  logic [7:0] exp_cmd [2];
  logic [7:0] held [2];
  logic [7:0] rx;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_q <= rst;
  end
  ussrt_responder #(.CMD_N(8), .RESP_N(8), .SAMPLE_EDGE(1), .CMD_MSB_FIRST(1), .RESP_MSB_FIRST(1), .SYNC_STAGES(2)) u0 (
    .clk(clk), .rst(rst), .csb(csb[0]), .sclk(sclk[0]), .sdi(sdi[0]), .sdo(sdo[0]), .cmd_data(cmd_data[0]),
    .cmd_valid(cmd_valid[0]), .resp_data(resp_data[0]), .resp_done(resp_done[0]), .frame_err(frame_err[0]), .busy(busy[0]));
  ussrt_responder #(.CMD_N(8), .RESP_N(8), .SAMPLE_EDGE(0), .CMD_MSB_FIRST(0), .RESP_MSB_FIRST(0), .SYNC_STAGES(3)) u1 (
    .clk(clk), .rst(rst), .csb(csb[1]), .sclk(sclk[1]), .sdi(sdi[1]), .sdo(sdo[1]), .cmd_data(cmd_data[1]),
    .cmd_valid(cmd_valid[1]), .resp_data(resp_data[1]), .resp_done(resp_done[1]), .frame_err(frame_err[1]), .busy(busy[1]));
  function automatic int syn(input int i);
    return i == 0 ? 2 : 3;
  endfunction
  function automatic logic msb(input int i);
    return i == 0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  // scoreboard: every pulse must be announced by the master model, cmd_data holds otherwise
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_q) begin
        chk($sformatf("u%0d reset outputs", i),
            {sdo[i], cmd_valid[i], resp_done[i], frame_err[i], busy[i], cmd_data[i]}, 0);
        held[i] = 8'h00;
        cv_pend[i] = 0;
        rd_pend[i] = 0;
        fe_pend[i] = 0;
      end else begin
        if (cmd_valid[i]) begin
          chk($sformatf("u%0d cmd_valid expected", i), cv_pend[i], 1);
          chk($sformatf("u%0d cmd_data", i), cmd_data[i], exp_cmd[i]);
          chk($sformatf("u%0d cmd latency ok", i), (cyc - t_cmd[i]) <= syn(i) + 2, 1);
          held[i] = exp_cmd[i];
          cv_pend[i] = 0;
        end else chk($sformatf("u%0d cmd_data hold", i), cmd_data[i], held[i]);
        if (resp_done[i]) begin
          chk($sformatf("u%0d resp_done expected", i), rd_pend[i] > 0, 1);
          if (rd_pend[i] > 0) rd_pend[i]--;
        end
        if (frame_err[i]) begin
          chk($sformatf("u%0d frame_err expected", i), fe_pend[i] > 0, 1);
          if (fe_pend[i] > 0) fe_pend[i]--;
        end
      end
    end
  end
  task automatic begin_frame(input int i, input int h);
    csb[i] = 1'b0;
    tick(h);
  endtask
  // one command/response word; stop < 16 ends after that many sample edges
  task automatic word(input int i, input logic [7:0] cmd, input logic [7:0] resp, input int stop, input int h,
                      output logic [7:0] rxo);
    logic e;
    rxo = 8'h00;
    resp_data[i] = resp;
    for (int k = 0; k < stop; k++) begin
      sdi[i] = k < 8 ? (msb(i) ? cmd[7-k] : cmd[k]) : $urandom_range(0, 1);
      tick(h);
      e = k < 8 ? 1'b0 : (msb(i) ? resp[15-k] : resp[k-8]);
      chk($sformatf("u%0d sdo bit %0d", i, k), sdo[i], e);
      chk($sformatf("u%0d busy bit %0d", i, k), busy[i], k != 0);
      if (k >= 8) rxo = {rxo[6:0], sdo[i]};
      sclk[i] = (i == 0);
      if (k == 7) begin
        exp_cmd[i] = cmd;
        cv_pend[i] = 1;
        t_cmd[i] = cyc;
      end
      if (k == 15) rd_pend[i]++;
      tick(h);
      sclk[i] = (i != 0);
    end
  endtask
  task automatic end_frame(input int i, input int stop, input int h);
    tick(h);
    if (stop > 0 && stop < 16) fe_pend[i]++;
    csb[i] = 1'b1;
    tick(syn(i) + 3);
    chk($sformatf("u%0d idle sdo", i), sdo[i], 0);
    chk($sformatf("u%0d idle busy", i), busy[i], 0);
    chk($sformatf("u%0d frame_err outstanding", i), fe_pend[i], 0);
    chk($sformatf("u%0d resp_done outstanding", i), rd_pend[i], 0);
    chk($sformatf("u%0d cmd_valid outstanding", i), cv_pend[i], 0);
  endtask
  initial begin
    int i, h, nw, stop;
    logic [7:0] c, r;
    csb[0] = 1'b1; csb[1] = 1'b1;
    sclk[0] = 1'b0; sclk[1] = 1'b1;
    sdi[0] = 1'b0; sdi[1] = 1'b0;
    resp_data[0] = 8'h00; resp_data[1] = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(4);
    begin_frame(0, 8);
    word(0, 8'hA5, 8'h3C, 16, 8, rx);
    end_frame(0, 16, 8);
    chk("u0 serial response 0x3C", rx, 8'h3C);
    chk("u0 cmd 0xA5", cmd_data[0], 8'hA5);
    begin_frame(1, 8);
    word(1, 8'h01, 8'h80, 16, 8, rx);
    end_frame(1, 16, 8);
    chk("u1 serial response 0x80 lsb first", rx, 8'h01);
    chk("u1 cmd 0x01", cmd_data[1], 8'h01);
    begin_frame(0, 6);
    word(0, 8'hFF, 8'h00, 5, 6, rx);
    end_frame(0, 5, 6);
    chk("u0 cmd kept after abort", cmd_data[0], 8'hA5);
    begin_frame(0, 6);
    word(0, 8'h5A, 8'hC3, 16, 6, rx);
    end_frame(0, 16, 6);
    chk("u0 cmd 0x5A", cmd_data[0], 8'h5A);
    begin_frame(0, 5);
    word(0, 8'h12, 8'h9E, 16, 5, rx);
    word(0, 8'h34, 8'h61, 16, 5, rx);
    end_frame(0, 16, 5);
    chk("u0 second b2b cmd 0x34", cmd_data[0], 8'h34);
    begin_frame(1, 6);
    word(1, 8'h3B, 8'hD2, 11, 6, rx);
    end_frame(1, 11, 6);
    begin_frame(0, 6);
    word(0, 8'h77, 8'hE1, 11, 6, rx);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("u0 cmd cleared by reset", cmd_data[0], 8'h00);
    end_frame(0, 0, 6);
    begin_frame(0, 7);
    word(0, 8'hC6, 8'h5D, 16, 7, rx);
    end_frame(0, 16, 7);
    chk("u0 serial response after reset", rx, 8'h5D);
    for (int it = 0; it < 40; it++) begin
      i = $urandom_range(0, 1);
      h = $urandom_range(5, 8);
      nw = $urandom_range(1, 3);
      stop = 16;
      begin_frame(i, h);
      for (int w = 0; w < nw; w++) begin
        c = 8'($urandom);
        r = 8'($urandom);
        stop = (w == nw - 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
        word(i, c, r, stop, h, rx);
      end
      end_frame(i, stop, h);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/ussrt_responder.md
Name: ussrt_responder

Overview:
Responder end of the team's synchronous serial link: the far side of the serial master that generates sclk, shifts a command word out, then clocks a response word back in. It runs on its own fast system clock and oversamples the incoming sclk/csb/sdi. It deserialises a CMD_N-bit command and presents it in parallel, then serialises a RESP_N-bit response back on sdo in the same frame. It sits in debugger/target logic as the slave endpoint of the serial port.

Parameters:
CMD_N, 8, bits per received command word (>=2)
RESP_N, 8, bits per transmitted response word (>=2)
SAMPLE_EDGE, 1, 1 = sample sdi on sclk rising edge and launch sdo on falling; 0 = inverse
CMD_MSB_FIRST, 1, 1 = first received bit lands in cmd_data[CMD_N-1]
RESP_MSB_FIRST, 1, 1 = resp_data[RESP_N-1] is transmitted first
SYNC_STAGES, 2, flip-flop stages on sclk, csb and sdi (>=2)

Ports:
clk  input  1  system clock; sclk half-period must be >= SYNC_STAGES+2 clk cycles
rst  input  1  synchronous reset, active-high
csb  input  1  frame select from master, active-low, asynchronous to clk
sclk  input  1  serial clock from master, asynchronous to clk
sdi  input  1  serial data from master
sdo  output  1  serial response data to master
cmd_data  output  CMD_N  last complete command word
cmd_valid  output  1  one-cycle pulse: cmd_data updated
resp_data  input  RESP_N  response word, captured in the cmd_valid cycle
resp_done  output  1  one-cycle pulse: last response bit sampled by master
frame_err  output  1  one-cycle pulse: csb deasserted mid-frame
busy  output  1  high in CMD (after first bit) or RESP state

Behaviour:
- Reset (rst high at posedge clk): state IDLE, counters 0, synchroniser stages 0, sdo=0, cmd_data=0, cmd_valid=0, resp_done=0, frame_err=0, busy=0. Reset wins over every other event.
- Synchronisers: sclk, csb and sdi each pass through SYNC_STAGES flops. Edges are detected from the last synced stage vs. one extra history flop. sdi is taken from the same stage depth as sclk, so data and clock stay aligned.
- Sample edge = synced sclk edge matching SAMPLE_EDGE; launch edge = opposite edge. Edges are ignored while synced csb is high.
- States:
  - IDLE: synced csb low -> CMD, bit counter=0.
  - CMD: each sample edge shifts sdi into a shift register and increments the counter. At the CMD_N-th sample edge:
    - cmd_data <= assembled word. The final bit is included in the same cycle; the bit order follows CMD_MSB_FIRST.
    - cmd_valid pulses in the cycle after the edge.
    - That cycle captures resp_data into the response shift register and goes to RESP with counter=0.
  - RESP:
    - sdo presents the first response bit from the cycle after capture.
    - Each launch edge advances sdo to the next bit. Response bit k (k=0..RESP_N-1) is valid for the (k+1)-th sample edge after the last command bit.
    - Each sample edge increments the counter. On the RESP_N-th sample edge: resp_done pulses, sdo <= 0, state -> CMD with counter=0, ready for the next frame without csb toggle.
- sdo is 0 in IDLE and CMD.
- csb synced high in any state: return to IDLE next cycle, counters cleared, sdo=0, no cmd_valid/resp_done. frame_err pulses only if the counter is nonzero or the state is RESP.
- Simultaneous csb rise and sample edge in the same cycle: the csb rise wins and the edge is discarded.
- cmd_data holds its value until the next complete command. It is not cleared by csb or frame_err, only by rst.
- busy = (CMD and counter!=0) or RESP.
- Counter width is clog2(max(CMD_N,RESP_N))+1. There is no wrap-around: the counter resets on each state change.
- Latency: cmd_valid rises SYNC_STAGES+2 clk cycles after the raw sclk sample edge of the last command bit.

Test Plan:
- Reset mid-RESP (rst high 1 cycle after 3 response bits): all outputs 0 next cycle, state IDLE; a following full frame works normally.
- Defaults, sclk period 16 clk, send cmd 0xA5 MSB first with resp_data=0x3C -> cmd_valid one pulse with cmd_data=0xA5; master samples 0,0,1,1,1,1,0,0; resp_done one pulse.
- CMD_MSB_FIRST=0, RESP_MSB_FIRST=0, SAMPLE_EDGE=0, send serial bits 1,0,0,0,0,0,0,0 on falling edges -> cmd_data=0x01. resp_data=0x80 returns serial 0,0,0,0,0,0,0,1.
- Two back-to-back frames 0x12 then 0x34 under one csb-low window -> two cmd_valid pulses with 0x12 then 0x34, two resp_done pulses, frame_err never asserted.
- csb raised after 5 command bits -> frame_err one pulse, no cmd_valid, cmd_data keeps its prior value 0xA5, sdo=0, busy=0. The next frame 0x5A decodes correctly.
- csb raised during RESP after 3 response bits -> frame_err pulse, no resp_done, sdo=0 within SYNC_STAGES+2 cycles.
